// File: rtl/ps2_keycode_if.sv
// PS/2 pin inputs and decoded key outputs of ps2_keycode.
// The master side drives the pins; the slave side is the decoder.
interface ps2_keycode_if;
   logic       ps2_clk;
   logic       ps2_data;
   logic [7:0] keycode;
   logic       key_event;
   logic       frame_err;

   modport master (
      output ps2_clk,
      output ps2_data,
      input  keycode,
      input  key_event,
      input  frame_err
   );

   modport slave (
      input  ps2_clk,
      input  ps2_data,
      output keycode,
      output key_event,
      output frame_err
   );
endinterface

// File: rtl/ps2_keycode.sv
// PS/2 scan code set 2 receiver. It turns make/break/extended sequences into the
// HID code of the mapped key that is currently held.
module ps2_keycode #(
   parameter int TIMEOUT_CYCLES = 50000
) (
   input logic          Clk,
   input logic          Reset,
   ps2_keycode_if.slave bus
);

   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

   typedef enum logic [1:0] {IDLE, EXT, BRK, EXT_BRK} prefix_t;

   logic          r_clkSync1;
   logic          r_clkSync2;
   logic          r_clkPrev;
   logic          r_dataSync1;
   logic          r_dataSync2;
   logic          w_fall;

   logic [3:0]    r_bitCnt;
   logic [7:0]    r_shift;
   logic          r_startBit;
   logic          r_parity;
   logic [TW-1:0] r_timeout;
   logic [7:0]    r_byte;
   logic          r_byteStrobe;
   logic          r_byteErr;
   logic          r_timeoutHit;

   prefix_t       r_state;
   logic [7:0]    r_keycode;
   logic          r_keyEvent;
   logic          r_frameErr;
   logic          w_mapExt;
   logic [8:0]    w_map;
   logic          w_mapped;
   logic [7:0]    w_hid;

   // {mapped, hid} for a scan code, qualified by the E0 prefix.
   function automatic logic [8:0] mapKey(input logic ext, input logic [7:0] scan);
      logic [8:0] result;
      result = 9'h000;
      case ({ext, scan})
         9'h01C:  result = {1'b1, 8'h04};
         9'h023:  result = {1'b1, 8'h07};
         9'h01D:  result = {1'b1, 8'h1A};
         9'h01B:  result = {1'b1, 8'h16};
         9'h029:  result = {1'b1, 8'h2C};
         9'h05A:  result = {1'b1, 8'h28};
         9'h16B:  result = {1'b1, 8'h50};
         9'h174:  result = {1'b1, 8'h4F};
         default: result = 9'h000;
      endcase
      return result;
   endfunction

   // Pin synchronizers. The clock path idles high, so a reset must not fake an edge.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         r_clkSync1  <= 1'b1;
         r_clkSync2  <= 1'b1;
         r_clkPrev   <= 1'b1;
         r_dataSync1 <= 1'b1;
         r_dataSync2 <= 1'b1;
      end else begin
         r_clkSync1  <= bus.ps2_clk;
         r_clkSync2  <= r_clkSync1;
         r_clkPrev   <= r_clkSync2;
         r_dataSync1 <= bus.ps2_data;
         r_dataSync2 <= r_dataSync1;
      end
   end

   assign w_fall = r_clkPrev & ~r_clkSync2;

   // Framing and the watchdog. If an edge and the timeout land on the same cycle, the edge wins.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         r_bitCnt     <= 4'd0;
         r_shift      <= 8'h00;
         r_startBit   <= 1'b0;
         r_parity     <= 1'b0;
         r_timeout    <= '0;
         r_byte       <= 8'h00;
         r_byteStrobe <= 1'b0;
         r_byteErr    <= 1'b0;
         r_timeoutHit <= 1'b0;
      end else begin
         r_byteStrobe <= 1'b0;
         r_byteErr    <= 1'b0;
         r_timeoutHit <= 1'b0;
         if (w_fall) begin
            r_timeout <= '0;
            case (r_bitCnt)
               4'd0: begin
                  r_startBit <= r_dataSync2;
                  r_bitCnt   <= 4'd1;
               end
               4'd9: begin
                  r_parity <= r_dataSync2;
                  r_bitCnt <= 4'd10;
               end
               4'd10: begin
                  r_bitCnt <= 4'd0;
                  r_byte   <= r_shift;
                  if (!r_startBit && r_dataSync2 && (^{r_shift, r_parity}))
                     r_byteStrobe <= 1'b1;
                  else
                     r_byteErr <= 1'b1;
               end
               default: begin
                  r_shift  <= {r_dataSync2, r_shift[7:1]};
                  r_bitCnt <= r_bitCnt + 4'd1;
               end
            endcase
         end else if (r_bitCnt != 4'd0) begin
            if (r_timeout == TW'(TIMEOUT_CYCLES - 1)) begin
               r_timeout    <= '0;
               r_bitCnt     <= 4'd0;
               r_timeoutHit <= 1'b1;
            end else begin
               r_timeout <= r_timeout + TW'(1);
            end
         end
      end
   end

   assign w_mapExt = (r_state == EXT) || (r_state == EXT_BRK);
   assign w_map    = mapKey(w_mapExt, r_byte);
   assign w_mapped = w_map[8];
   assign w_hid    = w_map[7:0];

   // Prefix FSM. Only a change of the held code raises key_event, so typematic repeats are silent.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         r_state    <= IDLE;
         r_keycode  <= 8'h00;
         r_keyEvent <= 1'b0;
         r_frameErr <= 1'b0;
      end else begin
         r_keyEvent <= 1'b0;
         r_frameErr <= 1'b0;
         if (r_byteErr || r_timeoutHit) begin
            r_frameErr <= 1'b1;
            r_state    <= IDLE;
         end else if (r_byteStrobe) begin
            case (r_state)
               IDLE, EXT: begin
                  if (r_byte == 8'hF0) begin
                     r_state <= (r_state == EXT) ? EXT_BRK : BRK;
                  end else if (r_byte == 8'hE0) begin
                     r_state <= EXT;
                  end else begin
                     r_state <= IDLE;
                     if (w_mapped && (w_hid != r_keycode)) begin
                        r_keycode  <= w_hid;
                        r_keyEvent <= 1'b1;
                     end
                  end
               end
               BRK, EXT_BRK: begin
                  r_state <= IDLE;
                  if ((r_byte != 8'hE0) && (r_byte != 8'hF0) && w_mapped && (w_hid == r_keycode)) begin
                     r_keycode  <= 8'h00;
                     r_keyEvent <= 1'b1;
                  end
               end
               default: r_state <= IDLE;
            endcase
         end
      end
   end

   assign bus.keycode   = r_keycode;
   assign bus.key_event = r_keyEvent;
   assign bus.frame_err = r_frameErr;

endmodule
